// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that sequences the shared 64K x 8 memory
// through a fixed IDLE -> ACCESS -> RESP cycle, driving the data bus only on writes.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_we,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ack,

    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_we,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ack,

    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              mem_write_enable,
    output logic              mem_chip_select,

    output logic              busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              grant_valid;
    logic              grant_port;
    logic              cur_port;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic              drive_bus;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Under contention the port that did not win last time gets the memory.
    always_comb begin
        state_next       = state;
        grant_valid      = 1'b0;
        grant_port       = 1'b0;
        mem_chip_select  = 1'b0;
        mem_write_enable = 1'b0;
        drive_bus        = 1'b0;
        busy             = 1'b1;
        p0_ack           = 1'b0;
        p1_ack           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (p0_req && p1_req) begin
                    grant_valid = 1'b1;
                    grant_port  = ~last_grant;
                end else if (p0_req || p1_req) begin
                    grant_valid = 1'b1;
                    grant_port  = p1_req;
                end
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_chip_select  = 1'b1;
                mem_write_enable = lat_we;
                drive_bus        = lat_we;
                state_next       = RESP;
            end
            RESP: begin
                p0_ack     = ~cur_port;
                p1_ack     = cur_port;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_addr = lat_addr;
    assign mem_data = drive_bus ? lat_wdata : {DATA_W{1'bz}};

    // Read data is captured from the bus on the edge that closes ACCESS.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            cur_port   <= 1'b0;
            last_grant <= 1'b1;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            if (grant_valid) begin
                cur_port   <= grant_port;
                last_grant <= grant_port;
                lat_addr   <= grant_port ? p1_addr  : p0_addr;
                lat_we     <= grant_port ? p1_we    : p0_we;
                lat_wdata  <= grant_port ? p1_wdata : p0_wdata;
            end
            if (state == ACCESS && !lat_we) begin
                if (cur_port) begin
                    p1_rdata <= mem_data;
                end else begin
                    p0_rdata <= mem_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model plus a bench-side
// memory device, compared every cycle, with directed scenarios and random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata;
    logic [7:0]  p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic [15:0] mem_addr;
    wire  [7:0]  mem_data;
    logic        mem_write_enable, mem_chip_select;
    logic        busy, last_grant;

    int passCount = 0;
    int checkCount = 0;

    logic [7:0] dev_mem [0:65535];
    logic [7:0] ref_mem [0:65535];

    // Transaction model: one outstanding access, aged by cycles since its grant.
    logic        m_active;
    int          m_age;
    logic        m_port;
    logic [15:0] m_addr;
    logic        m_we;
    logic [7:0]  m_wdata;
    logic        m_last;
    logic [7:0]  m_rdata [2];
    logic [7:0]  zByte;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .p0_req           (p0_req),
        .p0_addr          (p0_addr),
        .p0_we            (p0_we),
        .p0_wdata         (p0_wdata),
        .p0_rdata         (p0_rdata),
        .p0_ack           (p0_ack),
        .p1_req           (p1_req),
        .p1_addr          (p1_addr),
        .p1_we            (p1_we),
        .p1_wdata         (p1_wdata),
        .p1_rdata         (p1_rdata),
        .p1_ack           (p1_ack),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .mem_write_enable (mem_write_enable),
        .mem_chip_select  (mem_chip_select),
        .busy             (busy),
        .last_grant       (last_grant)
    );

    // Memory device: combinational read onto the bus, write on the clock edge.
    assign mem_data = (mem_chip_select && !mem_write_enable) ? dev_mem[mem_addr] : 8'bz;

    always @(posedge clk) begin
        if (mem_chip_select && mem_write_enable) dev_mem[mem_addr] <= mem_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic [15:0] addr,
                                 input logic we, input logic [7:0] wdata);
        if (port == 0) begin
            p0_req = req; p0_addr = addr; p0_we = we; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_addr = addr; p1_we = we; p1_wdata = wdata;
        end
    endtask

    task modelReset();
        m_active   = 1'b0;
        m_age      = 0;
        m_port     = 1'b0;
        m_addr     = 16'h0000;
        m_we       = 1'b0;
        m_wdata    = 8'h00;
        m_last     = 1'b1;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;
    endtask

    task modelAdvance();
        if (m_active) begin
            if (m_age == 1) begin
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rdata[m_port] = ref_mem[m_addr];
                m_age = 2;
            end else begin
                m_active = 1'b0;
            end
        end else if (p0_req || p1_req) begin
            if (p0_req && p1_req) m_port = ~m_last;
            else                  m_port = p1_req;
            m_addr   = m_port ? p1_addr  : p0_addr;
            m_we     = m_port ? p1_we    : p0_we;
            m_wdata  = m_port ? p1_wdata : p0_wdata;
            m_last   = m_port;
            m_active = 1'b1;
            m_age    = 1;
        end
    endtask

    // Compare every cycle on the falling edge, then advance the model with the inputs
    // the DUT will see on the next rising edge.
    always @(negedge clk) begin
        logic expCs, expAck0, expAck1;
        if (!reset_n) modelReset();
        expCs   = m_active && (m_age == 1);
        expAck0 = m_active && (m_age == 2) && !m_port;
        expAck1 = m_active && (m_age == 2) && m_port;
        checkOutput("busy", 32'(busy), 32'(m_active));
        checkOutput("chip_select", 32'(mem_chip_select), 32'(expCs));
        checkOutput("write_enable", 32'(mem_write_enable), 32'(expCs && m_we));
        checkOutput("p0_ack", 32'(p0_ack), 32'(expAck0));
        checkOutput("p1_ack", 32'(p1_ack), 32'(expAck1));
        checkOutput("p0_rdata", 32'(p0_rdata), 32'(m_rdata[0]));
        checkOutput("p1_rdata", 32'(p1_rdata), 32'(m_rdata[1]));
        checkOutput("last_grant", 32'(last_grant), 32'(m_last));
        if (expCs) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
            checkOutput("mem_data", 32'(mem_data), m_we ? 32'(m_wdata) : 32'(ref_mem[m_addr]));
        end else begin
            checkOutput("mem_data idle", 32'(mem_data), 32'(zByte));
        end
        if (!reset_n) checkOutput("mem_addr reset", 32'(mem_addr), 32'h0);
        if (reset_n) modelAdvance();
    end

    task automatic runAccess(input string name, input int port, input logic [15:0] addr,
                             input logic we, input logic [7:0] wdata, input logic [7:0] expRdata);
        int         lat;
        logic [7:0] rd;
        lat = 10;
        rd  = 8'hxx;
        @(posedge clk); #1;
        applyStimulus(port, 1'b1, addr, we, wdata);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_ack : p1_ack) begin
                lat = i;
                rd  = (port == 0) ? p0_rdata : p1_rdata;
                break;
            end
        end
        checkOutput({name, " latency"}, 32'(lat), 32'd2);
        checkOutput({name, " rdata"}, 32'(rd), 32'(expRdata));
        @(posedge clk); #1;
        applyStimulus(port, 1'b0, addr, we, wdata);
    endtask

    initial begin
        int   ackOrder [8];
        int   ackCount;
        int   overlap;
        logic a0, a1;

        zByte = 8'bz;
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        dev_mem[0] = 8'h08; ref_mem[0] = 8'h08;
        dev_mem[1] = 8'h60; ref_mem[1] = 8'h60;

        reset_n = 1'b0;
        applyStimulus(0, 1'b0, 16'h0, 1'b0, 8'h0);
        applyStimulus(1, 1'b0, 16'h0, 1'b0, 8'h0);

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            applyStimulus(0, 1'($urandom), 16'($urandom), 1'($urandom), 8'($urandom));
            applyStimulus(1, 1'($urandom), 16'($urandom), 1'($urandom), 8'($urandom));
        end
        @(negedge clk);
        checkOutput("reset last_grant", 32'(last_grant), 32'h1);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset cs", 32'(mem_chip_select), 32'h0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 16'h0, 1'b0, 8'h0);
        applyStimulus(1, 1'b0, 16'h0, 1'b0, 8'h0);
        reset_n = 1'b1;

        runAccess("p1 write", 1, 16'h1234, 1'b1, 8'hA5, 8'h00);
        runAccess("p1 read", 1, 16'h1234, 1'b0, 8'h00, 8'hA5);

        // Continuous contention: both held high for 12 cycles.
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 16'h0002, 1'b0, 8'h00);
        applyStimulus(1, 1'b1, 16'h0003, 1'b0, 8'h00);
        ackCount = 0;
        overlap  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (p0_ack && p1_ack) overlap++;
            if ((p0_ack || p1_ack) && ackCount < 8) begin
                ackOrder[ackCount] = p1_ack ? 1 : 0;
                ackCount++;
            end
        end
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 16'h0002, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 16'h0003, 1'b0, 8'h00);
        checkOutput("contention ack count", 32'(ackCount), 32'd4);
        checkOutput("contention overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("contention grant %0d", i), 32'(ackOrder[i]), 32'(i % 2));
        end

        runAccess("p0 fetch 0", 0, 16'h0000, 1'b0, 8'h00, 8'h08);
        runAccess("p0 fetch 1", 0, 16'h0001, 1'b0, 8'h00, 8'h60);

        // Late drop: req falls and addr changes during ACCESS.
        @(posedge clk); #1;
        applyStimulus(0, 1'b1, 16'h0001, 1'b0, 8'h00);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 16'h0002, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("late drop mem_addr", 32'(mem_addr), 32'h0001);
        @(negedge clk);
        checkOutput("late drop ack", 32'(p0_ack), 32'h1);
        checkOutput("late drop rdata", 32'(p0_rdata), 32'h60);

        // Reset asserted in the middle of a write ACCESS.
        @(posedge clk); #1;
        applyStimulus(1, 1'b1, 16'h0010, 1'b1, 8'h3C);
        @(posedge clk); #2;
        reset_n = 1'b0;
        applyStimulus(1, 1'b0, 16'h0010, 1'b1, 8'h3C);
        @(negedge clk);
        checkOutput("abort cs", 32'(mem_chip_select), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort no ack", 32'(p1_ack), 32'h0);
        end
        runAccess("abort readback", 1, 16'h0010, 1'b0, 8'h00, 8'h00);

        // Random traffic: requesters hold req until ack, sometimes withdraw early.
        a0 = 1'b0;
        a1 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = p0_ack;
            a1 = p1_ack;
            @(posedge clk); #1;
            if (p0_req && a0)
                applyStimulus(0, 1'b0, p0_addr, p0_we, p0_wdata);
            else if (!p0_req && $urandom_range(0, 2) == 0)
                applyStimulus(0, 1'b1, $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(65528, 65535)),
                              1'($urandom), 8'($urandom));
            else if (p0_req && $urandom_range(0, 15) == 0)
                applyStimulus(0, 1'b0, 16'($urandom), p0_we, p0_wdata);
            if (p1_req && a1)
                applyStimulus(1, 1'b0, p1_addr, p1_we, p1_wdata);
            else if (!p1_req && $urandom_range(0, 2) == 0)
                applyStimulus(1, 1'b1, $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(65528, 65535)),
                              1'($urandom), 8'($urandom));
            else if (p1_req && $urandom_range(0, 15) == 0)
                applyStimulus(1, 1'b0, 16'($urandom), p1_we, p1_wdata);
        end
        applyStimulus(0, 1'b0, 16'h0, 1'b0, 8'h0);
        applyStimulus(1, 1'b0, 16'h0, 1'b0, 8'h0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter and sequencer for the single-port 64K x 8 system memory (16-bit addr, 8-bit bidirectional data bus, write_enable, chip_select). It shares the memory between port 0 (instruction fetch) and port 1 (load/store) using req/ack handshakes and round-robin arbitration. It sequences each access as a fixed three-phase cycle so that only one agent drives the shared data bus at a time. It sits between the CPU front-end/LSU and the memory block.

Parameters:
ADDR_W, 16, address width (matches the memory address port)
DATA_W, 8, data width (matches the memory data port)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
p0_req  input  1  port 0 request; held high until p0_ack
p0_addr  input  ADDR_W  port 0 address
p0_we  input  1  port 0 write (1) / read (0)
p0_wdata  input  DATA_W  port 0 write data
p0_rdata  output  DATA_W  port 0 read data, valid while p0_ack=1, held afterwards
p0_ack  output  1  port 0 completion pulse, 1 cycle
p1_req, p1_addr, p1_we, p1_wdata, p1_rdata, p1_ack  same as port 0, for port 1
mem_addr  output  ADDR_W  memory address
mem_data  inout  DATA_W  memory data bus; driven only during write ACCESS, else high-Z
mem_write_enable  output  1  memory write enable
mem_chip_select  output  1  memory chip select
busy  output  1  1 when state != IDLE
last_grant  output  1  index of the most recently granted port

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; mem_addr=0, mem_write_enable=0, mem_chip_select=0, mem_data=high-Z; p0/p1_ack=0, p0/p1_rdata=0; busy=0; last_grant=1 (port 0 wins first contention).
- FSM states: IDLE, ACCESS, RESP. Each access takes exactly 3 cycles; there are no wait states.
- IDLE: cs=0, we=0, bus high-Z.
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port != last_grant.
  - On a grant: latch the granted addr/we/wdata, set last_grant to the granted port, and go to ACCESS on the next edge.
- ACCESS (1 cycle):
  - Outputs: mem_addr=latched addr, mem_chip_select=1, mem_write_enable=latched we.
  - Write: drive mem_data=latched wdata; the memory commits on the edge that ends ACCESS.
  - Read: mem_data is high-Z from the arbiter side; the memory drives it combinationally; the edge that ends ACCESS captures mem_data into the granted port's rdata.
  - Always go to RESP.
- RESP (1 cycle): the granted port's ack=1; cs=0, we=0, bus high-Z (this is the bus turnaround cycle); all req inputs are ignored; go to IDLE.
- Latency:
  - req high in IDLE cycle N -> ACCESS in N+1 -> ack in N+2 -> IDLE in N+3.
  - Peak throughput is 1 access per 3 cycles.
  - Under continuous contention, grants alternate 0,1,0,1.
- Requester rule: deassert req (or present a new request) in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- Input changes after the grant edge are ignored; the latched values are used.
- If req drops during ACCESS/RESP, the transaction still completes and ack is still issued.
- rdata for a port changes only on completion of a read for that port. Write completion leaves rdata unchanged.
- Only one ack is asserted in any cycle; acks never overlap.
- Bus exclusivity invariant: the arbiter drives mem_data only when state=ACCESS and the latched we=1. A cycle with mem_chip_select=1 and mem_write_enable=0 never coincides with arbiter drive.
- Reset mid-operation: outputs clear immediately. A write whose ACCESS is cut short by reset before the committing edge is not performed. No ack is issued for the aborted transaction.
- Address wraps naturally at 0xFFFF; there is no special handling.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> cs=0, we=0, mem_data=Z, acks=0, rdata=0, busy=0, last_grant=1.
- Single write/read: p1 writes 0xA5 to 0x1234 -> ack at N+2. Then p1 reads 0x1234 -> p1_rdata=0xA5 with p1_ack, exactly 3 cycles per access.
- Preloaded fetch: p0 reads 0x0000 and 0x0001 -> p0_rdata=0x08, then 0x60. The bus is never driven by the arbiter.
- Contention: p0 and p1 both held high (reads 0x0002 and 0x0003) for 12 cycles -> grants alternate p0,p1,p0,p1; each ack is 1 cycle; acks never overlap.
- Late drop and input change: p0 drops req and changes addr during ACCESS -> access uses the original addr and p0_ack still pulses.
- Reset mid-write: write 0x3C to 0x0010 (old value 0x00), assert reset_n=0 during ACCESS before the edge -> no ack; a later read of 0x0010 returns 0x00.
